mcu_bus_router: RTL

Parametrised memory-request router between the CPU sequencer and N memory/peripheral targets. It generalises the fixed two-way split of fetch/load/store traffic between the SPI memory controller and the peripheral block. Requests are decoded against per-target base/mask windows, issued to one target with a handshake, and guarded by a timeout. The master receives a single ack/error response.

---
 rtl/mcu_bus_router.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/mcu_bus_router.sv
// mcu_bus_router: decodes CPU memory requests onto N_TGT targets through base/mask windows,
// issues a one-hot handshake and returns one ack/err. Define ROUTER_TIMEOUT_EN for the watchdog.

module mcu_bus_router #(
    parameter int                        ADDR_W      = 16,
    parameter int                        DATA_W      = 8,
    parameter int                        RDATA_W     = 16,
    parameter int                        N_TGT       = 2,
    parameter logic [N_TGT*ADDR_W-1:0]   TGT_BASE    = {16'h0000, 16'hF000},
    parameter logic [N_TGT*ADDR_W-1:0]   TGT_MASK    = {16'h8000, 16'hF000},
    parameter int                        TIMEOUT_CYC = 255
) (
    input  logic                       clk_in,
    input  logic                       reset_n_in,
    input  logic                       m_req_in,
    input  logic [1:0]                 m_type_in,
    input  logic [ADDR_W-1:0]          m_addr_in,
    input  logic [DATA_W-1:0]          m_wdata_in,
    output logic [RDATA_W-1:0]         m_rdata_out,
    output logic                       m_ack_out,
    output logic                       m_err_out,
    output logic [N_TGT-1:0]           t_valid_out,
    output logic [1:0]                 t_type_out,
    output logic [ADDR_W-1:0]          t_addr_out,
    output logic [DATA_W-1:0]          t_wdata_out,
    input  logic [N_TGT-1:0]           t_busy_in,
    input  logic [N_TGT-1:0]           t_done_in,
    input  logic [N_TGT*RDATA_W-1:0]   t_rdata_in
);

    localparam int SEL_W = (N_TGT > 1) ? $clog2(N_TGT) : 1;
    localparam logic [RDATA_W-1:0] LOAD_MASK = RDATA_W'({DATA_W{1'b1}});

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR} state_t;
    typedef enum logic [1:0] {REQ_NONE = 2'b00, REQ_IMEM = 2'b01,
                              REQ_DREAD = 2'b10, REQ_DWRITE = 2'b11} req_t;

    state_t              state_q, state_d;
    req_t                type_q;
    logic [SEL_W-1:0]    sel_q, hit_idx;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [RDATA_W-1:0]  rdata_q, rdata_d, sel_rdata;
    logic                hit, start, sel_busy, sel_done, timeout;

    // Iterate downwards so the lowest matching window wins.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = N_TGT - 1; i >= 0; i--) begin
            if ((m_addr_in & TGT_MASK[i*ADDR_W +: ADDR_W]) ==
                (TGT_BASE[i*ADDR_W +: ADDR_W] & TGT_MASK[i*ADDR_W +: ADDR_W])) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
    end

    assign start     = (state_q == S_IDLE) && m_req_in && (m_type_in != REQ_NONE);
    assign sel_busy  = t_busy_in[sel_q];
    assign sel_done  = t_done_in[sel_q];
    assign sel_rdata = t_rdata_in[int'(sel_q)*RDATA_W +: RDATA_W];

`ifdef ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt_q, cnt_next;
    logic             in_flight;

    assign in_flight = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign cnt_next  = (cnt_q == CNT_LIMIT) ? cnt_q : cnt_q + 1'b1;
    assign timeout   = in_flight && (cnt_next == CNT_LIMIT);

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (in_flight) begin
            cnt_q <= cnt_next;
        end
    end
`else
    // Without the watchdog a transaction waits forever; TIMEOUT_CYC has no effect here.
    assign timeout = (TIMEOUT_CYC < 0);
`endif

    always_comb begin
        state_d     = state_q;
        t_valid_out = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) state_d = hit ? S_ISSUE : S_ERR;
            end
            S_ISSUE: begin
                if (!sel_busy) t_valid_out[sel_q] = 1'b1;
                if (timeout)        state_d = S_ERR;
                else if (!sel_busy) state_d = S_WAIT;
            end
            S_WAIT: begin
                // A completion in the expiry cycle still counts as success.
                if (sel_done)     state_d = S_RESP;
                else if (timeout) state_d = S_ERR;
            end
            S_RESP:  state_d = S_IDLE;
            S_ERR:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rdata_d = rdata_q;
        if (state_d == S_ERR) begin
            rdata_d = '0;
        end else if (state_q == S_WAIT && sel_done) begin
            unique case (type_q)
                REQ_IMEM:  rdata_d = sel_rdata;
                REQ_DREAD: rdata_d = sel_rdata & LOAD_MASK;
                default:   rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q <= S_IDLE;
            type_q  <= REQ_NONE;
            sel_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            rdata_q <= rdata_d;
            if (start) begin
                type_q  <= req_t'(m_type_in);
                sel_q   <= hit_idx;
                addr_q  <= m_addr_in;
                wdata_q <= m_wdata_in;
            end
        end
    end

    assign m_ack_out   = (state_q == S_RESP) || (state_q == S_ERR);
    assign m_err_out   = (state_q == S_ERR);
    assign m_rdata_out = rdata_q;
    assign t_type_out  = type_q;
    assign t_addr_out  = addr_q;
    assign t_wdata_out = wdata_q;

endmodule
